// File: rtl/dmem_pkg.sv
// dmem_pkg: shared func3 encodings, FSM state type and access-size helper for the data-memory arbiter
package dmem_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;

  // Bytes touched by an access; only meaningful for legal func3 values
  function automatic logic [2:0] acc_size(logic [2:0] func3);
    return func3[1] ? 3'd4 : func3[0] ? 3'd2 : 3'd1;
  endfunction
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one requester port of the data-memory arbiter
interface dmem_arbiter_if #(parameter int ADDR_W = 32) ();
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [2:0]        func3;
  logic [31:0]       wdata;
  logic              gnt;
  logic              rvalid;
  logic [31:0]       rdata;
  logic              err;

  modport master (output req, we, addr, func3, wdata, input gnt, rvalid, rdata, err);
  modport slave  (input req, we, addr, func3, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/dmem_req_check.sv
// dmem_req_check: flags illegal func3, misalignment and out-of-range accesses
module dmem_req_check
  import dmem_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = 64
) (
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        func3,
  output logic              err
);
  logic            bad_f3;
  logic            misal;
  logic [ADDR_W:0] end_addr;

  // The extra top bit keeps addr + size from wrapping near the top of the address space
  always_comb begin
    bad_f3   = we ? !(func3 inside {F3_B, F3_H, F3_W})
                  : !(func3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    misal    = (func3[1:0] == 2'b01 && addr[0]) || (func3[1:0] == 2'b10 && addr[1:0] != 2'b00);
    end_addr = {1'b0, addr} + (ADDR_W+1)'(acc_size(func3));
    err      = bad_f3 || misal || end_addr > (ADDR_W+1)'(MEM_BYTES);
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port arbiter and one-cycle sequencer for the data memory
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_arbiter_if.slave     m0,
  dmem_arbiter_if.slave     m1,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_func3,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  state_t            state, state_nx;
  logic              last;
  logic              gnt0, gnt1;
  logic              c_we, c_err;
  logic [ADDR_W-1:0] c_addr;
  logic [2:0]        c_f3;
  logic              t_port, t_we, t_err;
  logic [ADDR_W-1:0] t_addr;
  logic [2:0]        t_f3;
  logic [31:0]       t_wdata, rdata_q;
  logic              mem_on, resp;

  dmem_req_check #(.ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES)) u_chk (
    .we   (c_we),
    .addr (c_addr),
    .func3(c_f3),
    .err  (c_err)
  );

  // Arbitrate in IDLE/RESP; a tie goes to the port that did not win last time
  always_comb begin
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    state_nx = RESP;
    if (state != MEM) begin
      gnt0     = rst_n && m0.req && (!m1.req || last);
      gnt1     = rst_n && m1.req && (!m0.req || !last);
      state_nx = (gnt0 || gnt1) ? MEM : IDLE;
    end
    c_we   = gnt1 ? m1.we    : m0.we;
    c_addr = gnt1 ? m1.addr  : m0.addr;
    c_f3   = gnt1 ? m1.func3 : m0.func3;
  end

  // Memory is driven only in MEM and only for an access that passed the checks
  always_comb begin
    mem_on    = state == MEM && !t_err;
    resp      = state == RESP;
    mem_we    = mem_on && t_we;
    mem_addr  = mem_on ? t_addr  : '0;
    mem_func3 = mem_on ? t_f3    : '0;
    mem_wdata = mem_on ? t_wdata : '0;
  end

  assign m0.gnt    = gnt0;
  assign m1.gnt    = gnt1;
  assign m0.rvalid = resp && !t_port;
  assign m1.rvalid = resp && t_port;
  assign m0.err    = m0.rvalid && t_err;
  assign m1.err    = m1.rvalid && t_err;
  assign m0.rdata  = m0.rvalid ? rdata_q : '0;
  assign m1.rdata  = m1.rvalid ? rdata_q : '0;

  // State, round-robin pointer, transaction register and captured load data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      last    <= 1'b1;
      t_port  <= 1'b0;
      t_we    <= 1'b0;
      t_err   <= 1'b0;
      t_addr  <= '0;
      t_f3    <= '0;
      t_wdata <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nx;
      if (gnt0 || gnt1) begin
        last    <= gnt1;
        t_port  <= gnt1;
        t_we    <= c_we;
        t_err   <= c_err;
        t_addr  <= c_addr;
        t_f3    <= c_f3;
        t_wdata <= gnt1 ? m1.wdata : m0.wdata;
      end
      if (state == MEM) rdata_q <= (t_we || t_err) ? '0 : mem_rdata;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: random and directed checks of dmem_arbiter against a transaction-level model
module tb_dmem_arbiter;
  import dmem_pkg::*;
  localparam int AW = 32;
  localparam int MB = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(AW)) m0 ();
  dmem_arbiter_if #(.ADDR_W(AW)) m1 ();
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [2:0]    mem_func3;
  logic [31:0]   mem_wdata, mem_rdata;

  dmem_arbiter #(.ADDR_W(AW), .MEM_BYTES(MB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .m0       (m0),
    .m1       (m1),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_func3(mem_func3),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ext(logic [31:0] raw, logic [2:0] f3);
    case (f3)
      3'b000:  return {{24{raw[7]}}, raw[7:0]};
      3'b001:  return {{16{raw[15]}}, raw[15:0]};
      3'b100:  return {24'h0, raw[7:0]};
      3'b101:  return {16'h0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  function automatic int bi(logic [31:0] a, int i);
    return int'((a + 32'(i)) % MB);
  endfunction

  // Memory environment: combinational extended read, write at the clock edge
  logic [7:0] mem[MB];
  logic [7:0] ref_mem[MB];
  assign mem_rdata = ext({mem[bi(mem_addr, 3)], mem[bi(mem_addr, 2)], mem[bi(mem_addr, 1)], mem[bi(mem_addr, 0)]}, mem_func3);
  always @(posedge clk)
    if (mem_we)
      for (int i = 0; i < (1 << mem_func3[1:0]); i++) mem[bi(mem_addr, i)] = mem_wdata[8*i +: 8];

  function automatic bit model_err(bit we, logic [31:0] a, logic [2:0] f3);
    int  s = 1 << f3[1:0];
    bit  legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    return !legal || (a % s != 0) || (longint'({32'h0, a}) + s > MB);
  endfunction

  typedef struct {
    bit          v;
    bit          p;
    bit          we;
    logic [31:0] a;
    logic [2:0]  f3;
    logic [31:0] wd;
    bit          e;
    logic [31:0] rd;
  } tx_t;

  tx_t s1, s2;
  bit  last_m = 1'b1;

  // Reference model: s1 is the transaction in its memory cycle, s2 the one responding
  always @(negedge clk) begin
    tx_t n;
    int  w;
    if (!rst_n) begin
      check("rst_ctl", {m0.gnt, m1.gnt, m0.rvalid, m1.rvalid, m0.err, m1.err, mem_we}, 0);
      check("rst_data", {m0.rdata | m1.rdata | mem_wdata, mem_addr, 29'h0, mem_func3}, 0);
      s1.v = 0;
      s2.v = 0;
      last_m = 1'b1;
    end else begin
      check("rvalid0", m0.rvalid, s2.v && !s2.p);
      check("rvalid1", m1.rvalid, s2.v && s2.p);
      check("rdata0", m0.rdata, (s2.v && !s2.p) ? s2.rd : 0);
      check("rdata1", m1.rdata, (s2.v && s2.p) ? s2.rd : 0);
      check("err0", m0.err, s2.v && !s2.p && s2.e);
      check("err1", m1.err, s2.v && s2.p && s2.e);
      if (s1.v && !s1.e) begin
        check("mem_we", mem_we, s1.we);
        check("mem_addr", mem_addr, s1.a);
        check("mem_func3", mem_func3, s1.f3);
        if (s1.we) begin
          check("mem_wdata", mem_wdata, s1.wd);
          for (int i = 0; i < (1 << s1.f3[1:0]); i++) ref_mem[bi(s1.a, i)] = s1.wd[8*i +: 8];
        end else
          s1.rd = ext({ref_mem[bi(s1.a, 3)], ref_mem[bi(s1.a, 2)], ref_mem[bi(s1.a, 1)], ref_mem[bi(s1.a, 0)]}, s1.f3);
      end else
        check("mem_idle", {mem_we, mem_addr, mem_func3, mem_wdata}, 0);
      w = -1;
      if (!s1.v) w = (m0.req && m1.req) ? 1 - int'(last_m) : m0.req ? 0 : m1.req ? 1 : -1;
      check("gnt0", m0.gnt, w == 0);
      check("gnt1", m1.gnt, w == 1);
      n.v  = w >= 0;
      n.p  = w == 1;
      n.we = n.p ? m1.we : m0.we;
      n.a  = n.p ? m1.addr : m0.addr;
      n.f3 = n.p ? m1.func3 : m0.func3;
      n.wd = n.p ? m1.wdata : m0.wdata;
      n.e  = model_err(n.we, n.a, n.f3);
      n.rd = 0;
      if (n.v) last_m = n.p;
      s2 = s1;
      s1 = n;
    end
  end

  task automatic set_port(bit p, bit r, bit we, logic [31:0] a, logic [2:0] f3, logic [31:0] wd);
    if (p) begin
      m1.req = r; m1.we = we; m1.addr = a; m1.func3 = f3; m1.wdata = wd;
    end else begin
      m0.req = r; m0.we = we; m0.addr = a; m0.func3 = f3; m0.wdata = wd;
    end
  endtask

  task automatic idle();
    set_port(0, 0, 0, 0, 0, 0);
    set_port(1, 0, 0, 0, 0, 0);
  endtask

  // One isolated transaction, called just after a rising edge outside MEM
  task automatic xact(bit p, bit we, logic [31:0] a, logic [2:0] f3, logic [31:0] wd,
                      output logic [31:0] rd, output bit e);
    set_port(p, 1, we, a, f3, wd);
    @(posedge clk); #1 idle();
    @(posedge clk);
    @(negedge clk);
    rd = p ? m1.rdata : m0.rdata;
    e  = p ? m1.err : m0.err;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rd;
    bit          e;
    logic [31:0] keep;
    for (int i = 0; i < MB; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    idle();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    xact(0, 1, 8, F3_W, 32'hDEADBEEF, rd, e);
    check("st8_err", e, 0);
    xact(0, 0, 8, F3_W, 0, rd, e);
    check("ld8_data", rd, 32'hDEADBEEF);
    check("ld8_err", e, 0);
    xact(1, 0, 3, F3_H, 0, rd, e);
    check("lh3_err", e, 1);
    check("lh3_data", rd, 0);
    xact(0, 0, 62, F3_W, 0, rd, e);
    check("lw62_err", e, 1);
    xact(0, 0, 60, F3_W, 0, rd, e);
    check("lw60_err", e, 0);
    xact(0, 1, 8, F3_BU, 32'h12345678, rd, e);
    check("sbu_err", e, 1);
    xact(0, 0, 8, F3_W, 0, rd, e);
    check("sbu_nowrite", rd, 32'hDEADBEEF);

    keep = {ref_mem[23], ref_mem[22], ref_mem[21], ref_mem[20]};
    set_port(0, 1, 1, 20, F3_W, ~keep);
    @(posedge clk); #1 idle();
    check("mem_we_pre", mem_we, 1);
    #1 rst_n = 1'b0;
    #1 check("mem_we_rst", mem_we, 0);
    @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_norvalid", {m0.rvalid, m1.rvalid}, 0);

    set_port(0, 1, 0, 12, F3_W, 0);
    set_port(1, 1, 0, 32, F3_HU, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("alt_g0", m0.gnt, k % 4 == 0);
      check("alt_g1", m1.gnt, k % 4 == 2);
      @(posedge clk); #1;
    end
    idle();
    repeat (3) @(posedge clk);
    #1 xact(1, 0, 20, F3_W, 0, rd, e);
    check("rst_nowrite", rd, keep);

    repeat (500) begin
      for (int p = 0; p < 2; p++) begin
        logic [2:0] f3;
        f3 = ($urandom % 4 == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
        if (f3 != F3_W && $urandom % 2 == 0 && f3 != 3'd2) f3[2] = f3[1:0] != 2'b10;
        set_port(p[0], $urandom % 4 != 0, $urandom % 2 == 0,
                 ($urandom % 8 == 0) ? $urandom : $urandom_range(0, 70), f3, $urandom);
      end
      @(posedge clk); #1;
    end
    idle();
    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
